// File: rtl/tt_mux_sel_pkg.sv
// tt_mux_sel_pkg: shared types and constants for the project-select sequencer.
package tt_mux_sel_pkg;

  // Default number of clock cycles per control-pulse phase.
  localparam int HALF_PERIOD_DEF = 4;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIS    = 3'd1,
    ST_RST_LO = 3'd2,
    ST_RST_HI = 3'd3,
    ST_INC_HI = 3'd4,
    ST_INC_LO = 3'd5,
    ST_ENA    = 3'd6
  } state_t;

endpackage

// File: rtl/tt_mux_sel_phase_timer.sv
// tt_mux_sel_phase_timer: loadable down-counter that marks the last cycle of
// a HALF_PERIOD-long control phase. Loading sets the counter to
// HALF_PERIOD-1, so a phase entered with load lasts exactly HALF_PERIOD cycles.
module tt_mux_sel_phase_timer #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int CNT_W = $clog2(HALF_PERIOD + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_r;

  // Phase counter: reload on phase entry, count down to zero and hold there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/tt_mux_sel_sequencer.sv
// tt_mux_sel_sequencer: drives the chip's project-select pads
// (ctrl_ena, ctrl_sel_inc, ctrl_sel_rst_n) to select the project at sel_addr.
// Sequence: disable, pulse selection reset, N increment pulses, re-enable.
// All pad outputs are registered from the current FSM state, so there is no
// combinational path from start/sel_addr to the pads.
// Optional macro TT_MUX_SEL_INCREMENTAL_EN: when the current selection is
// valid and not above the target, skip the reset pulse and issue only the
// difference in increments.
module tt_mux_sel_sequencer
  import tt_mux_sel_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sel_addr,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              addr_valid,
  output logic              ctrl_ena,
  output logic              ctrl_sel_inc,
  output logic              ctrl_sel_rst_n
);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] n_r, n_s;
  logic [ADDR_W-1:0] rem_r, rem_s;
  logic              expire_s;
  logic              load_s;

  logic              busy_r, done_r, addr_valid_r;
  logic              ena_r, inc_r, rst_n_r;
  logic [ADDR_W-1:0] cur_addr_r;

  // Every state change starts a fresh phase.
  assign load_s = (state_s != state_r);

  tt_mux_sel_phase_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .expire(expire_s)
  );

  // FSM state, target address and remaining-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      n_r     <= {ADDR_W{1'b0}};
      rem_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_s;
      n_r     <= n_s;
      rem_r   <= rem_s;
    end
  end

  // Next-state logic: each timed phase advances when the phase timer expires.
  always_comb begin
    state_s = state_r;
    n_s     = n_r;
    rem_s   = rem_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_DIS;
          n_s     = sel_addr;
          rem_s   = sel_addr;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DIS: begin
        if (expire_s) begin
`ifdef TT_MUX_SEL_INCREMENTAL_EN
          if (addr_valid_r && (n_r >= cur_addr_r)) begin
            rem_s   = n_r - cur_addr_r;
            state_s = (n_r == cur_addr_r) ? ST_ENA : ST_INC_HI;
          end else begin
            state_s = ST_RST_LO;
          end
`else
          state_s = ST_RST_LO;
`endif
        end else begin
          state_s = ST_DIS;
        end
      end
      ST_RST_LO: begin
        if (expire_s) begin
          state_s = ST_RST_HI;
        end else begin
          state_s = ST_RST_LO;
        end
      end
      ST_RST_HI: begin
        if (expire_s) begin
          state_s = (rem_r != {ADDR_W{1'b0}}) ? ST_INC_HI : ST_ENA;
        end else begin
          state_s = ST_RST_HI;
        end
      end
      ST_INC_HI: begin
        if (expire_s) begin
          state_s = ST_INC_LO;
        end else begin
          state_s = ST_INC_HI;
        end
      end
      ST_INC_LO: begin
        if (expire_s) begin
          // Count reaches zero after the last pulse; full-scale N cannot wrap.
          rem_s   = rem_r - ADDR_W'(1);
          state_s = (rem_r == ADDR_W'(1)) ? ST_ENA : ST_INC_HI;
        end else begin
          state_s = ST_INC_LO;
        end
      end
      ST_ENA: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Registered pad and status outputs decoded from the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cur_addr_r   <= {ADDR_W{1'b0}};
      addr_valid_r <= 1'b0;
      ena_r        <= 1'b0;
      inc_r        <= 1'b0;
      rst_n_r      <= 1'b1;
    end else begin
      busy_r  <= (state_r != ST_IDLE);
      done_r  <= (state_r == ST_ENA);
      inc_r   <= (state_r == ST_INC_HI);
      rst_n_r <= (state_r != ST_RST_LO);
      if (state_r == ST_DIS) begin
        ena_r <= 1'b0;
      end else if (state_r == ST_ENA) begin
        ena_r <= 1'b1;
      end else begin
        ena_r <= ena_r;
      end
      if (state_r == ST_ENA) begin
        cur_addr_r   <= n_r;
        addr_valid_r <= 1'b1;
      end else begin
        cur_addr_r   <= cur_addr_r;
        addr_valid_r <= addr_valid_r;
      end
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign cur_addr       = cur_addr_r;
  assign addr_valid     = addr_valid_r;
  assign ctrl_ena       = ena_r;
  assign ctrl_sel_inc   = inc_r;
  assign ctrl_sel_rst_n = rst_n_r;

endmodule

// File: tb/tb_tt_mux_sel_sequencer.sv
// tb_tt_mux_sel_sequencer: directed-vector bench for tt_mux_sel_sequencer
// (ADDR_W=8, HALF_PERIOD=4). Expected values are hand-computed from the
// sequence timing: done at cycle H*(3+2N)+1 on the full path, or
// H*(1+2(N-cur))+1 on the incremental path when TT_MUX_SEL_INCREMENTAL_EN is set.
module tb_tt_mux_sel_sequencer;

  localparam int H = 4;
`ifdef TT_MUX_SEL_INCREMENTAL_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] sel_addr;
  logic       start;
  logic       busy, done, addr_valid, ctrl_ena, ctrl_sel_inc, ctrl_sel_rst_n;
  logic [7:0] cur_addr;

  int n_tests = 0;
  int n_fail  = 0;

  tt_mux_sel_sequencer #(.ADDR_W(8), .HALF_PERIOD(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .sel_addr      (sel_addr),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .cur_addr      (cur_addr),
    .addr_valid    (addr_valid),
    .ctrl_ena      (ctrl_ena),
    .ctrl_sel_inc  (ctrl_sel_inc),
    .ctrl_sel_rst_n(ctrl_sel_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".busy"},     int'(busy), 0);
    check_eq({tag, ".done"},     int'(done), 0);
    check_eq({tag, ".cur"},      int'(cur_addr), 0);
    check_eq({tag, ".valid"},    int'(addr_valid), 0);
    check_eq({tag, ".ena"},      int'(ctrl_ena), 0);
    check_eq({tag, ".inc"},      int'(ctrl_sel_inc), 0);
    check_eq({tag, ".rst_n"},    int'(ctrl_sel_rst_n), 1);
  endtask

  // Run one select sequence and check pad waveform and completion.
  // ign_at >= 1 re-asserts start (with a different address) in that cycle.
  task automatic run_seq(input string tag, input logic [7:0] addr, input int exp_done,
                         input int exp_inc, input int exp_rstlo, input int ign_at);
    int cyc, done_cyc, inc_cnt, rstlo_cnt, bad_gap, bad_hi, overlap, last_rise, hi_len;
    int busy1, ena_at_done, busy_after, done_after;
    logic prev_inc;
    done_cyc = -1; inc_cnt = 0; rstlo_cnt = 0; bad_gap = 0; bad_hi = 0; overlap = 0;
    last_rise = -1; hi_len = 0; busy1 = -1; ena_at_done = -1; busy_after = -1; done_after = -1;
    @(negedge clk);
    sel_addr = addr;
    start    = 1'b1;
    @(posedge clk);      // edge 0
    #1;
    start    = 1'b0;
    sel_addr = 8'hAA;
    prev_inc = ctrl_sel_inc;
    for (cyc = 1; cyc <= exp_done + 40; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == ign_at + 1) start = 1'b0;
      if (cyc == 1) busy1 = int'(busy);
      if (done_cyc >= 0) begin
        busy_after = int'(busy);
        done_after = int'(done);
        break;
      end
      if (done) begin
        done_cyc    = cyc;
        ena_at_done = int'(ctrl_ena);
      end
      if (ctrl_sel_inc && !prev_inc) begin
        inc_cnt++;
        if (last_rise >= 0 && (cyc - last_rise) != 2 * H) bad_gap++;
        last_rise = cyc;
        hi_len    = 0;
      end
      if (ctrl_sel_inc) hi_len++;
      if (!ctrl_sel_inc && prev_inc && hi_len != H) bad_hi++;
      if (!ctrl_sel_rst_n) rstlo_cnt++;
      if (!ctrl_sel_rst_n && ctrl_sel_inc) overlap++;
      prev_inc = ctrl_sel_inc;
      if (cyc == ign_at) begin
        start    = 1'b1;
        sel_addr = 8'd9;
      end
    end
    start = 1'b0;
    check_eq({tag, ".done_cycle"},  done_cyc, exp_done);
    check_eq({tag, ".inc_pulses"},  inc_cnt, exp_inc);
    check_eq({tag, ".rst_lo_cyc"},  rstlo_cnt, exp_rstlo);
    check_eq({tag, ".inc_gap"},     bad_gap, 0);
    check_eq({tag, ".inc_hi_len"},  bad_hi, 0);
    check_eq({tag, ".overlap"},     overlap, 0);
    check_eq({tag, ".busy_c1"},     busy1, 1);
    check_eq({tag, ".ena_at_done"}, ena_at_done, 1);
    check_eq({tag, ".busy_after"},  busy_after, 0);
    check_eq({tag, ".done_1cyc"},   done_after, 0);
    check_eq({tag, ".cur_addr"},    int'(cur_addr), int'(addr));
    check_eq({tag, ".addr_valid"},  int'(addr_valid), 1);
    check_eq({tag, ".ena_hold"},    int'(ctrl_ena), 1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    sel_addr = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    repeat (20) @(posedge clk);
    #1;
    check_reset_outputs("idle");

    // Full path N=5 and N=0 (N=0 is below cur=5, so full path in both builds).
    run_seq("sel5", 8'd5, 53, 5, H, -1);
    run_seq("sel0", 8'd0, 13, 0, H, -1);

    // Second start during the sequence is ignored.
    if (INC_EN) run_seq("ign4", 8'd4, 37, 4, 0, 10);
    else        run_seq("ign4", 8'd4, 45, 4, H, 10);

    // Reset in the middle of the 3rd increment-high phase.
    pulse_rst();
    @(negedge clk);
    sel_addr = 8'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_eq("midrst.in_inc_hi", int'(ctrl_sel_inc), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_seq("after_rst2", 8'd2, 29, 2, H, -1);

    // Select 3 from a fresh reset, then 7, then 1.
    pulse_rst();
    run_seq("sel3", 8'd3, 37, 3, H, -1);
    if (INC_EN) run_seq("sel7", 8'd7, 37, 4, 0, -1);
    else        run_seq("sel7", 8'd7, 69, 7, H, -1);
    run_seq("sel1", 8'd1, 21, 1, H, -1);

    // Full-scale count: no wrap of the pulse counter.
    if (INC_EN) run_seq("sel255", 8'd255, 2037, 254, 0, -1);
    else        run_seq("sel255", 8'd255, 2053, 255, H, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
